output_packer: RTL and testbench
================================

# output_packer

Parametrised output data stage between the accumulator array and the bidirectional `con_*` pads. It accepts one accumulator result per handshake and requantises it to IO width with a programmable right shift, round-half-up and signed saturation. Results are packed into groups of `NB_LANES` pad words and buffered in a group FIFO. Each group is presented to the pads with a valid/ready handshake, plus the tri-state enable for the pad drivers.

## Interface
- `ACC_WIDTH`, 32: signed accumulator input width.
- `IO_DATA_WIDTH`, 16: signed width of one pad word.
- `NB_LANES`, 3: pad words per group (number of `con_*` buses); ≥1.
- `FIFO_DEPTH`, 4: groups buffered; power of two, ≥2.
- `SHIFT_WIDTH`, 5: width of `shift_amt`.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `arst_in`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `in_data`  in  `ACC_WIDTH`  signed accumulator result.
- `in_last`  in  1  with an accepted sample: close the current group after this sample.
- `shift_amt`  in  `SHIFT_WIDTH`  right-shift amount; quasi-static, change only while idle.
- `out_valid`  out  1  FIFO head group is valid.
- `out_ready`  in  1  pad side consumes the head group.
- `out_data`  out  `NB_LANES*IO_DATA_WIDTH`  head group; lane k is at bits [k*IO_DATA_WIDTH +: IO_DATA_WIDTH].
- `out_lane_mask`  out  `NB_LANES`  bit k set means lane k holds real data.
- `driving_cons`  out  1  pad tri-state enable; equals `out_valid`.
- `sat_flag`  out  1  sticky flag: some accepted sample saturated.
- `sat_clr`  in  1  clears `sat_flag`.

## Operation
- **Accept:** a sample is accepted when `in_valid && in_ready`.
  - `in_ready = !fifo_full`, decoded from registered state.
  - A pop in the same cycle does not lift `in_ready`.
- **Requantise** (combinational, computed in `ACC_WIDTH+1` bits so nothing overflows):
  - Let s = min(`shift_amt`, `ACC_WIDTH-1`).
  - If s > 0, add 2^(s-1).
  - Arithmetic right shift by s.
  - Clamp to [-2^(IO_DATA_WIDTH-1), 2^(IO_DATA_WIDTH-1)-1].
  - Net effect is round-half-toward-+inf.
- **Saturation flag:**
  - `sat_flag` sets on any accepted sample whose value was clamped.
  - `sat_clr` clears it.
  - If `sat_clr` and a new saturation occur in the same cycle, the flag is 1.
- **Packer:**
  - Holds a lane index 0..`NB_LANES-1`, a partial group register and a partial mask.
  - Each accepted sample writes lane [idx] and sets mask[idx].
- **Group close:**
  - Closing condition: idx = `NB_LANES-1`, or `in_last`.
  - On close, the full group (new sample included) is pushed into the FIFO in the same cycle.
  - Unwritten lanes are 0 with mask bits 0.
  - Packer resets: idx = 0, register and mask cleared.
  - Otherwise idx increments.
- **FIFO:**
  - Storage is `FIFO_DEPTH` entries of (data, mask).
  - Head output is fall-through: `out_data`/`out_lane_mask` come directly from the head entry; all zeros when empty.
  - Pop when `out_valid && out_ready`.
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
  - A push is never attempted when full, because `in_ready` is low.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Group order:** groups leave in acceptance order; lane order inside a group follows acceptance order.

## Timing
- **Reset values:** while `arst_in` is high, and after it releases:
  - `out_valid`=0, `driving_cons`=0, `out_data`=0, `out_lane_mask`=0, `sat_flag`=0.
  - `in_ready`=1.
  - Packer idx=0; FIFO empty.
- **Reset mid-operation:** all buffered and partial groups are discarded. Nothing is emitted after reset.
- **Latency:** sample closing a group accepted at edge t → `out_valid`=1 from t+1, with that group on `out_data` if the FIFO was empty.
- **Throughput:** one sample per cycle; one group per cycle on the output side.
- **Backpressure:** `in_ready` falls the cycle after the FIFO becomes full. It rises the cycle after the first pop.
- **Output hold:** `out_data`/`out_lane_mask` are stable while `out_valid && !out_ready`.

## Test plan
Defaults (`ACC_WIDTH`=32, `IO_DATA_WIDTH`=16, `NB_LANES`=3, `FIFO_DEPTH`=4) unless a scenario states otherwise.
- **Basic packing:** `shift_amt`=0; samples 5, -7, 100 on consecutive cycles with `out_ready`=1 → one cycle later `out_valid`=1, lanes {5, -7, 100}, mask 3'b111, `driving_cons`=1. Popped that cycle.
- **Rounding:** `shift_amt`=4; samples 24, -24, 23 → lanes {2, -1, 1}; `sat_flag` stays 0.
- **Saturation:** `shift_amt`=0; samples 40000, -40000, 32767 → lanes {32767, -32768, 32767}; `sat_flag`=1.
  - Pulse `sat_clr` with no input → 0.
  - `sat_clr` in the same cycle as an accepted 70000 → stays 1.
- **Partial group:** samples 1, 2 with `in_last` on 2 → lanes {1, 2, 0}, mask 3'b011. Next samples 3, 4, 5 form a new full group {3, 4, 5}.
- **Backpressure:** `out_ready`=0; stream 14 samples 1..14 with `in_valid` held → 12 accepted (4 groups), `in_ready`=0, sample 13 held.
  - Raise `out_ready` → groups {1,2,3}..{10,11,12} in order.
  - `in_ready` returns one cycle after the first pop; samples 13, 14 are then accepted.
- **Reset mid-operation:** 2 groups queued plus 1 partial sample, assert `arst_in` for 1 cycle → `out_valid`=0, `out_data`=0, `in_ready`=1.
  - Next samples 7, 8, 9 → single group {7, 8, 9}, mask 3'b111.

Source files
------------

// File: rtl/output_packer.sv
// Output stage: requantises accumulator results to pad width, packs them into
// NB_LANES-wide groups and queues the groups in a small FIFO for the pads.
module output_packer #(
  parameter int ACC_WIDTH     = 32,
  parameter int IO_DATA_WIDTH = 16,
  parameter int NB_LANES      = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int SHIFT_WIDTH   = 5
) (
  input  logic                              clk,
  input  logic                              arst_in,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ACC_WIDTH-1:0]              in_data,
  input  logic                              in_last,
  input  logic [SHIFT_WIDTH-1:0]            shift_amt,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NB_LANES*IO_DATA_WIDTH-1:0] out_data,
  output logic [NB_LANES-1:0]               out_lane_mask,
  output logic                              driving_cons,
  output logic                              sat_flag,
  input  logic                              sat_clr
);

  localparam int EW = ACC_WIDTH + 1;
  localparam int GW = NB_LANES * IO_DATA_WIDTH;
  localparam int IW = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic signed [EW-1:0] MAX_V = (EW'(1) << (IO_DATA_WIDTH - 1)) - EW'(1);
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

  logic [31:0]                w_shift;
  logic signed [EW-1:0]       w_ext;
  logic signed [EW-1:0]       w_round;
  logic signed [EW-1:0]       w_shr;
  logic [IO_DATA_WIDTH-1:0]   w_q;
  logic                       w_sat;

  logic [IW-1:0]              r_idx;
  logic [GW-1:0]              r_part_data;
  logic [NB_LANES-1:0]        r_part_mask;
  logic                       w_accept;
  logic                       w_close;
  logic [GW-1:0]              w_grp_data;
  logic [NB_LANES-1:0]        w_grp_mask;

  logic [GW-1:0]              r_mem_data [FIFO_DEPTH];
  logic [NB_LANES-1:0]        r_mem_mask [FIFO_DEPTH];
  logic [PW-1:0]              r_wr_ptr;
  logic [PW-1:0]              r_rd_ptr;
  logic [PW:0]                r_count;
  logic                       w_full;
  logic                       w_pop;
  logic                       r_sat;

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    w_q     = '0;
    w_sat   = 1'b0;
    w_shift = (32'(shift_amt) > 32'(ACC_WIDTH - 1)) ? 32'(ACC_WIDTH - 1) : 32'(shift_amt);
    w_ext   = $signed({in_data[ACC_WIDTH-1], in_data});
    w_round = (w_shift == 32'd0) ? '0 : $signed(EW'(1) << (w_shift - 32'd1));
    w_shr   = (w_ext + w_round) >>> w_shift;
    if (w_shr > MAX_V) begin
      w_q   = MAX_V[IO_DATA_WIDTH-1:0];
      w_sat = 1'b1;
    end else if (w_shr < MIN_V) begin
      w_q   = MIN_V[IO_DATA_WIDTH-1:0];
      w_sat = 1'b1;
    end else begin
      w_q   = w_shr[IO_DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    w_accept   = in_valid && in_ready;
    w_close    = w_accept && (in_last || (r_idx == IW'(NB_LANES - 1)));
    w_grp_data = r_part_data;
    w_grp_mask = r_part_mask;
    for (int k = 0; k < NB_LANES; k++) begin
      if (r_idx == IW'(k)) begin
        w_grp_data[k*IO_DATA_WIDTH +: IO_DATA_WIDTH] = w_q;
        w_grp_mask[k]                                = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (arst_in) begin
      r_idx       <= '0;
      r_part_data <= '0;
      r_part_mask <= '0;
    end else if (w_accept) begin
      if (w_close) begin
        r_idx       <= '0;
        r_part_data <= '0;
        r_part_mask <= '0;
      end else begin
        r_idx       <= r_idx + IW'(1);
        r_part_data <= w_grp_data;
        r_part_mask <= w_grp_mask;
      end
    end
  end

  assign w_full = (r_count == (PW + 1)'(FIFO_DEPTH));
  assign w_pop  = out_valid && out_ready;

  // NOTE: FIFO storage is not reset; the count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_close) begin
      r_mem_data[r_wr_ptr] <= w_grp_data;
      r_mem_mask[r_wr_ptr] <= w_grp_mask;
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_close) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_close, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A new saturation wins over a simultaneous clear.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in)                r_sat <= 1'b0;
    else if (w_accept && w_sat) r_sat <= 1'b1;
    else if (sat_clr)           r_sat <= 1'b0;
  end

  assign in_ready      = !w_full;
  assign out_valid     = (r_count != '0);
  assign driving_cons  = out_valid;
  assign out_data      = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_lane_mask = out_valid ? r_mem_mask[r_rd_ptr] : '0;
  assign sat_flag      = r_sat;

endmodule

// File: tb/tb_output_packer.sv
// Bench for output_packer: directed scenarios plus randomized traffic, checked
// against an arithmetic reference model of requantise/pack/queue behaviour.
module tb_output_packer;

  localparam int AW  = 32;
  localparam int IOW = 16;
  localparam int NL  = 3;
  localparam int FD  = 4;
  localparam int SW  = 5;
  localparam int GW  = NL * IOW;

  logic          clk = 1'b0;
  logic          arst_in;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_data;
  logic          in_last;
  logic [SW-1:0] shift_amt;
  logic          out_valid;
  logic          out_ready;
  logic [GW-1:0] out_data;
  logic [NL-1:0] out_lane_mask;
  logic          driving_cons;
  logic          sat_flag;
  logic          sat_clr;

  output_packer #(
    .ACC_WIDTH(AW), .IO_DATA_WIDTH(IOW), .NB_LANES(NL), .FIFO_DEPTH(FD), .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk), .arst_in(arst_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .shift_amt(shift_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane_mask(out_lane_mask), .driving_cons(driving_cons),
    .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] d; bit last; } smp_t;
  typedef struct { logic [GW-1:0] d; logic [NL-1:0] m; } grp_t;

  smp_t           sendq[$];
  grp_t           exp_q[$];
  grp_t           got[$];
  logic [IOW-1:0] part[$];
  bit             exp_sat = 1'b0;
  bit             gaps    = 1'b0;
  bit             acc_this;
  int             n_checks = 0;
  int             n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round half toward +inf by floor((v + p/2) / p), then clamp to pad range.
  function automatic void quant(input logic [AW-1:0] d, input int sh,
                                output logic [IOW-1:0] q, output bit sat);
    longint v, p, lim;
    int s;
    s   = (sh > AW - 1) ? AW - 1 : sh;
    p   = longint'(1) << s;
    lim = longint'(1) << (IOW - 1);
    v   = longint'($signed(d));
    if (s > 0) v = v + p / 2;
    if (v >= 0) v = v / p;
    else        v = -((-v + p - 1) / p);
    sat = 1'b1;
    if (v > lim - 1)   q = IOW'(lim - 1);
    else if (v < -lim) q = IOW'(-lim);
    else begin
      q   = v[IOW-1:0];
      sat = 1'b0;
    end
  endfunction

  function automatic logic [GW-1:0] pack3(input int a, input int b, input int c);
    return {IOW'(c), IOW'(b), IOW'(a)};
  endfunction

  task automatic send(input int v, input bit last);
    smp_t s;
    s.d    = AW'(v);
    s.last = last;
    sendq.push_back(s);
  endtask

  task automatic drive_next();
    if (sendq.size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
      in_valid = 1'b1;
      in_data  = sendq[0].d;
      in_last  = sendq[0].last;
    end else begin
      in_valid = 1'b0;
      in_data  = $urandom();
      in_last  = 1'($urandom_range(0, 1));
    end
  endtask

  // One clock: compare DUT against the model at the falling edge, advance the
  // model through the coming rising edge, then drive the next inputs.
  task automatic step();
    logic [IOW-1:0] q;
    bit   sat;
    bit   exp_valid, exp_ready;
    grp_t g;
    @(negedge clk);
    if (arst_in) begin
      exp_q.delete();
      part.delete();
      exp_sat = 1'b0;
    end
    exp_valid = (exp_q.size() > 0);
    exp_ready = (exp_q.size() < FD);
    check("out_valid", out_valid, exp_valid);
    check("driving_cons", driving_cons, exp_valid);
    check("in_ready", in_ready, exp_ready);
    check("sat_flag", sat_flag, exp_sat);
    if (exp_valid) begin
      check("out_data", out_data, exp_q[0].d);
      check("out_lane_mask", out_lane_mask, exp_q[0].m);
    end else begin
      check("out_data_idle", out_data, '0);
      check("out_lane_mask_idle", out_lane_mask, '0);
    end
    if (out_valid && out_ready) begin
      g.d = out_data;
      g.m = out_lane_mask;
      got.push_back(g);
    end
    acc_this = !arst_in && in_valid && in_ready;
    if (!arst_in) begin
      if (exp_valid && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_ready) begin
        quant(in_data, int'(shift_amt), q, sat);
        if (sat)          exp_sat = 1'b1;
        else if (sat_clr) exp_sat = 1'b0;
        part.push_back(q);
        if (in_last || part.size() == NL) begin
          g.d = '0;
          g.m = '0;
          foreach (part[k]) begin
            g.d[k*IOW +: IOW] = part[k];
            g.m[k]            = 1'b1;
          end
          exp_q.push_back(g);
          part.delete();
        end
      end else if (sat_clr) begin
        exp_sat = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (acc_this) void'(sendq.pop_front());
    drive_next();
  endtask

  task automatic flush(input int budget);
    int n = 0;
    while ((sendq.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("flush_in_budget", n < budget, 1'b1);
  endtask

  initial begin
    arst_in   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    sat_clr   = 1'b0;
    shift_amt = '0;

    // Reset state, during and after reset
    step();
    step();
    arst_in = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);

    // Basic packing and one-cycle latency
    out_ready = 1'b1;
    got.delete();
    send(5, 0); send(-7, 0); send(100, 0);
    drive_next();
    repeat (4) step();
    check("basic_count", got.size(), 1);
    if (got.size() > 0) begin
      check("basic_data", got[0].d, pack3(5, -7, 100));
      check("basic_mask", got[0].m, 3'b111);
    end

    // Rounding
    shift_amt = 5'd4;
    got.delete();
    send(24, 0); send(-24, 0); send(23, 0);
    drive_next();
    flush(20);
    check("round_count", got.size(), 1);
    if (got.size() > 0) check("round_data", got[0].d, pack3(2, -1, 1));
    check("round_no_sat", sat_flag, 1'b0);

    // Saturation and sticky flag
    shift_amt = 5'd0;
    got.delete();
    send(40000, 0); send(-40000, 0); send(32767, 0);
    drive_next();
    flush(20);
    if (got.size() > 0) check("sat_data", got[0].d, pack3(32767, -32768, 32767));
    check("sat_set", sat_flag, 1'b1);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_cleared", sat_flag, 1'b0);
    send(70000, 1);
    drive_next();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_clr_vs_new_sat", sat_flag, 1'b1);
    flush(20);

    // Partial group then a full group
    got.delete();
    send(1, 0); send(2, 1); send(3, 0); send(4, 0); send(5, 0);
    drive_next();
    flush(30);
    check("partial_count", got.size(), 2);
    if (got.size() > 1) begin
      check("partial_data", got[0].d, pack3(1, 2, 0));
      check("partial_mask", got[0].m, 3'b011);
      check("after_partial_data", got[1].d, pack3(3, 4, 5));
      check("after_partial_mask", got[1].m, 3'b111);
    end

    // Backpressure: FIFO fills after 12 samples
    out_ready = 1'b0;
    got.delete();
    for (int i = 1; i <= 14; i++) send(i, i == 14);
    drive_next();
    repeat (14) step();
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_samples_held", sendq.size(), 2);
    check("bp_nothing_popped", got.size(), 0);
    out_ready = 1'b1;
    step();
    check("bp_in_ready_back", in_ready, 1'b1);
    flush(40);
    check("bp_count", got.size(), 5);
    if (got.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("bp_group%0d", i), got[i].d, pack3(3*i + 1, 3*i + 2, 3*i + 3));
        check($sformatf("bp_mask%0d", i), got[i].m, 3'b111);
      end
      check("bp_tail_data", got[4].d, pack3(13, 14, 0));
      check("bp_tail_mask", got[4].m, 3'b011);
    end

    // Reset mid-operation discards queued and partial groups
    out_ready = 1'b0;
    got.delete();
    for (int i = 1; i <= 7; i++) send(i, 0);
    drive_next();
    repeat (8) step();
    check("pre_rst_valid", out_valid, 1'b1);
    arst_in  = 1'b1;
    in_valid = 1'b0;
    step();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, '0);
    check("midrst_in_ready", in_ready, 1'b1);
    arst_in   = 1'b0;
    out_ready = 1'b1;
    step();
    got.delete();
    send(7, 0); send(8, 0); send(9, 0);
    drive_next();
    flush(20);
    check("postrst_count", got.size(), 1);
    if (got.size() > 0) begin
      check("postrst_data", got[0].d, pack3(7, 8, 9));
      check("postrst_mask", got[0].m, 3'b111);
    end

    // Randomized traffic against the model
    gaps = 1'b1;
    for (int b = 0; b < 6; b++) begin
      shift_amt = (b == 5) ? 5'd31 : (b == 4) ? 5'd16 : 5'($urandom_range(0, 8));
      for (int i = 0; i < 60; i++) begin
        if (sendq.size() < 4) begin
          case ($urandom_range(0, 3))
            0:       send(int'($urandom_range(0, 200)) - 100, $urandom_range(0, 3) == 0);
            1:       send(int'($urandom()), $urandom_range(0, 3) == 0);
            2:       send(($urandom_range(0, 1) == 1) ? 32'h7fff_ffff : 32'h8000_0000, 1'b0);
            default: send(int'($urandom_range(0, 1 << 20)) - (1 << 19), $urandom_range(0, 3) == 0);
          endcase
        end
        out_ready = ($urandom_range(0, 3) != 0);
        sat_clr   = ($urandom_range(0, 7) == 0);
        step();
      end
      send(0, 1);
      out_ready = 1'b1;
      sat_clr   = 1'b0;
      flush(200);
    end
    gaps = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
